fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller on the consumer side of the program counter.
- Samples the PC value and issues a read to instruction memory. Waits for the memory handshake, then loads the instruction register.
- Pulses the PC's increment/enable controls exactly once per completed fetch, and presents the fetched word to decode with a valid/ack handshake.

Parameters:
- ADDR_W, 9, memory address width; mem_addr = pc_value[ADDR_W-1:0].
- TIMEOUT_CYCLES, 16, max WAIT cycles before fault; used only with FETCH_TIMEOUT_EN.

Ports:
- clock, in, 1, single system clock; all state changes on posedge.
- clear, in, 1, asynchronous active-high reset.
- fetch_req, in, 1, level request for the next instruction.
- flush, in, 1, abort the in-flight fetch and discard the held IR (branch redirect).
- pc_value, in, 32, current PC register output.
- inc_pc, out, 1, one-cycle PC increment strobe.
- pc_enable, out, 1, one-cycle PC write enable; always asserted together with inc_pc.
- mem_addr, out, ADDR_W, instruction memory address.
- mem_read, out, 1, memory read request.
- mem_ready, in, 1, memory read data valid this cycle.
- mem_data, in, 32, memory read data.
- ir_out, out, 32, instruction register.
- ir_valid, out, 1, ir_out holds an unconsumed instruction.
- ir_ack, in, 1, decode consumes ir_out.
- busy, out, 1, high in any state other than IDLE.
- fetch_fault, out, 1, sticky timeout fault (FETCH_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset (clear=1, async): state=IDLE; mem_addr=0, mem_read=0, inc_pc=0, pc_enable=0, ir_out=0, ir_valid=0, busy=0, fetch_fault=0, timeout counter=0.
- States: IDLE, ADDR, WAIT, LATCH, HOLD, DRAIN.
- IDLE:
  - On fetch_req=1, register mem_addr <= pc_value[ADDR_W-1:0], then go to ADDR.
  - pc_value is sampled only here.
- ADDR:
  - mem_read=1 for this cycle; next state is WAIT.
  - flush=1 -> IDLE, mem_read deasserted, no PC change.
- WAIT:
  - mem_read held 1.
  - mem_ready=1 -> ir_out <= mem_data, then LATCH.
  - flush=1 with mem_ready=0 -> DRAIN.
  - flush=1 with mem_ready=1 -> IDLE, IR unchanged, no increment.
- LATCH:
  - inc_pc=1 and pc_enable=1 for exactly this cycle; mem_read=0; next state is HOLD with ir_valid=1.
  - flush in LATCH: the increment still occurs; go to IDLE with ir_valid=0. The redirect source overwrites the PC afterwards.
- HOLD:
  - ir_valid=1 and ir_out stable until ir_ack.
  - ir_ack=1 and fetch_req=1 -> sample pc_value, go to ADDR (back-to-back fetch, ir_valid drops the same edge).
  - ir_ack=1 and fetch_req=0 -> IDLE.
  - flush=1 -> IDLE, ir_valid=0; flush has priority over ir_ack.
- DRAIN:
  - mem_read=0; ignore mem_data; stay until mem_ready=1, then IDLE.
  - fetch_req is ignored here.
- Latency: fetch_req in IDLE to ir_valid = 3 + N cycles, where N = number of WAIT cycles before mem_ready (N>=1). With mem_ready asserted on the first WAIT cycle, the latency is 4 edges.
- The PC is incremented by exactly 1 per fetch that reaches LATCH; never on a flushed fetch.
- mem_ready outside WAIT/DRAIN is ignored.
- Reset mid-fetch drops mem_read immediately, with no PC strobe.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without mem_ready: fetch_fault <= 1 (sticky until clear), state -> IDLE, no PC increment.
  - fetch_req is ignored while fetch_fault=1.
- Undefined: no counter; WAIT holds indefinitely; fetch_fault is constant 0.

Decomposition:
- Shared package:
  - The state encoding enum (IDLE=0, ADDR=1, WAIT=2, LATCH=3, HOLD=4, DRAIN=5).
  - Constant WORD_W=32.
  - Default ADDR_W.
- One natural sub-module: fetch_timeout_counter (counter plus compare), instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Basic fetch: pc_value=5, mem_data=32'hA1B2C3D4, mem_ready on the 2nd WAIT cycle -> mem_addr=5; ir_out=A1B2C3D4; ir_valid after 5 edges; inc_pc and pc_enable high exactly 1 cycle.
- Back-to-back: fetch_req held, ir_ack asserted the first HOLD cycle, pc_value 5 then 6 -> second read at address 6; exactly 2 increment pulses total.
- Flush in WAIT with mem_ready delayed 3 cycles -> DRAIN; no IR load; no inc_pc; IDLE after mem_ready; next fetch uses the new pc_value=40.
- Flush and ir_ack together in HOLD -> ir_valid=0, state IDLE, even with fetch_req=1.
- Async clear asserted mid-WAIT -> all outputs 0 immediately, without waiting for a clock edge; no inc_pc pulse afterwards.
- With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready never asserted -> fetch_fault=1 after 4 WAIT cycles; no increment; subsequent fetch_req ignored until clear.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Imported by the interface, the timeout counter and the top.
package fetch_sequencer_pkg;

  localparam int WORD_W                 = 32;
  localparam int DEFAULT_ADDR_W         = 9;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;
  localparam int TIMEOUT_CNT_W          = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WAIT  = 3'd2,
    LATCH = 3'd3,
    HOLD  = 3'd4,
    DRAIN = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of PC-side, memory-side and decode-side signals of the fetch sequencer.
// master = the sequencer itself, slave = its surroundings (PC, memory, decode).
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) ();

  logic              fetch_req;
  logic              flush;
  logic [WORD_W-1:0] pc_value;
  logic              inc_pc;
  logic              pc_enable;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_ready;
  logic [WORD_W-1:0] mem_data;
  logic [WORD_W-1:0] ir_out;
  logic              ir_valid;
  logic              ir_ack;
  logic              busy;
  logic              fetch_fault;

  modport master (
    input  fetch_req, flush, pc_value, mem_ready, mem_data, ir_ack,
    output inc_pc, pc_enable, mem_addr, mem_read, ir_out, ir_valid, busy, fetch_fault
  );

  modport slave (
    output fetch_req, flush, pc_value, mem_ready, mem_data, ir_ack,
    input  inc_pc, pc_enable, mem_addr, mem_read, ir_out, ir_valid, busy, fetch_fault
  );

endinterface

// File: rtl/fetch_sequencer_timeout_counter.sv
// WAIT-state watchdog: counts consecutive WAIT cycles and flags the last allowed one.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_timeout_counter
  import fetch_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic clear,
  input  logic counting,
  output logic expired
);

  localparam logic [TIMEOUT_CNT_W-1:0] LAST_COUNT = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_CNT_W-1:0] count;

  // Count holds the number of WAIT cycles already completed; it restarts at 0 on every WAIT entry.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count <= '0;
    end else if (!counting) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = counting && (count == LAST_COUNT);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: samples the PC, reads instruction memory, loads the IR
// and hands it to decode. Optional WAIT watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic               clock,
  input logic               clear,
  fetch_sequencer_if.master bus
);

  fetch_state_e state;
  fetch_state_e next_state;
  logic         sample_pc;
  logic         load_ir;
  logic         timeout_hit;
  logic         fault_q;

  // NOTE: registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state gets a default before the case so no path infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (bus.fetch_req && !fault_q) next_state = ADDR;
      end
      ADDR: begin
        next_state = bus.flush ? IDLE : WAIT;
      end
      WAIT: begin
        // Flush wins over both a returning read and the watchdog.
        if (bus.flush)          next_state = bus.mem_ready ? IDLE : DRAIN;
        else if (bus.mem_ready) next_state = LATCH;
        else if (timeout_hit)   next_state = IDLE;
      end
      LATCH: begin
        next_state = bus.flush ? IDLE : HOLD;
      end
      HOLD: begin
        if (bus.flush)       next_state = IDLE;
        else if (bus.ir_ack) next_state = bus.fetch_req ? ADDR : IDLE;
      end
      DRAIN: begin
        if (bus.mem_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_read  = (state == ADDR) || (state == WAIT);
    bus.inc_pc    = (state == LATCH);
    bus.pc_enable = (state == LATCH);
    bus.ir_valid  = (state == HOLD);
    bus.busy      = (state != IDLE);
    // ADDR is only ever entered from IDLE or HOLD, which are exactly the PC sampling points.
    sample_pc     = (next_state == ADDR);
    load_ir       = (state == WAIT) && (next_state == LATCH);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      bus.mem_addr <= '0;
      bus.ir_out   <= '0;
    end else begin
      if (sample_pc) bus.mem_addr <= bus.pc_value[ADDR_W-1:0];
      if (load_ir)   bus.ir_out   <= bus.mem_data;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic counting;

  assign counting = (state == WAIT);

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .clear   (clear),
    .counting(counting),
    .expired (timeout_hit)
  );

  // Leaving WAIT for IDLE without a flush can only mean the watchdog fired.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      fault_q <= 1'b0;
    end else if ((state == WAIT) && (next_state == IDLE) && !bus.flush) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fault_q     = 1'b0;
`endif

  assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table, hand-written corner cases and
// a randomized run against a transaction-level PC/memory/decode model.
module tb_fetch_sequencer;

  localparam int ADDR_W = 9;

  logic clock = 1'b0;
  logic clear = 1'b1;

  fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_sequencer #(
    .ADDR_W        (ADDR_W),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: bench-side PC register and fetch bookkeeping.
  int unsigned pc_reg;
  bit          inc_seen;
  int          inc_count;
  int          delivered;
  int          streak;

  typedef struct {
    bit          req, flush, ready, ack;
    logic [31:0] pc, data;
    bit          rd, inc, vld, bsy;
    logic [31:0] ir, addr;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_pc();
    tick();
    if (inc_seen) pc_reg = pc_reg + 1;
    inc_seen = bus.inc_pc;
    if (bus.inc_pc) inc_count++;
    bus.pc_value = pc_reg;
  endtask

  task automatic do_reset();
    bus.fetch_req = 1'b0;
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_data  = '0;
    bus.ir_ack    = 1'b0;
    bus.pc_value  = '0;
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
  endtask

  function automatic vec_t mk(bit req, bit flush, bit ready, bit ack, logic [31:0] pc,
                              logic [31:0] data, bit rd, bit inc, bit vld, bit bsy,
                              logic [31:0] ir, logic [31:0] addr);
    vec_t v;
    v.req = req; v.flush = flush; v.ready = ready; v.ack = ack;
    v.pc = pc; v.data = data;
    v.rd = rd; v.inc = inc; v.vld = vld; v.bsy = bsy;
    v.ir = ir; v.addr = addr;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One randomized cycle: PC model, memory responder and decode consumer.
  task automatic rand_cycle(input bit allow_req, input int unsigned pc_start);
    bit ack;
    tick_pc();
    if (bus.inc_pc) check("rand.pc_enable", bus.pc_enable, 1'b1);
    if (bus.mem_read) begin
      streak++;
      check("rand.mem_addr", 32'(bus.mem_addr), 32'(pc_reg[ADDR_W-1:0]));
      bus.mem_ready = (streak >= 4) || ($urandom_range(0, 2) == 0);
      bus.mem_data  = bus.mem_ready ? mem_word(bus.mem_addr) : $urandom;
    end else begin
      streak        = 0;
      bus.mem_ready = ($urandom_range(0, 3) == 0);
      bus.mem_data  = $urandom;
    end
    if (bus.ir_valid) begin
      ack = allow_req ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ack) begin
        check("rand.ir_out", bus.ir_out, mem_word(ADDR_W'(pc_start + 32'(delivered))));
        delivered++;
      end
      bus.ir_ack = ack;
    end else begin
      bus.ir_ack = 1'b0;
    end
    bus.fetch_req = allow_req && ($urandom_range(0, 3) != 0);
  endtask

  initial begin : main
    localparam logic [31:0] A = 32'hA1B2_C3D4;
    localparam logic [31:0] B = 32'h1111_1111;
    localparam logic [31:0] C = 32'h2222_2222;
    localparam logic [31:0] G = 32'hBAD0_BAD0;
    logic [ADDR_W-1:0] addrs[$];
    int          got;
    bit          prev_read;
    int unsigned pc_start;

    // ---------------- reset state ----------------
    do_reset();
    check("reset.mem_read", bus.mem_read, 1'b0);
    check("reset.inc_pc", bus.inc_pc, 1'b0);
    check("reset.pc_enable", bus.pc_enable, 1'b0);
    check("reset.mem_addr", 32'(bus.mem_addr), 32'd0);
    check("reset.ir_out", bus.ir_out, 32'd0);
    check("reset.ir_valid", bus.ir_valid, 1'b0);
    check("reset.busy", bus.busy, 1'b0);
    check("reset.fetch_fault", bus.fetch_fault, 1'b0);

    // ---------------- vector table ----------------
    //                  req flu rdy ack pc  data | rd inc vld bsy ir addr
    tbl.push_back(mk(1, 0, 0, 0,  5, G, 1, 0, 0, 1, 0, 5));  // IDLE -> ADDR
    tbl.push_back(mk(0, 0, 0, 0,  5, G, 1, 0, 0, 1, 0, 5));  // -> WAIT
    tbl.push_back(mk(0, 0, 0, 0,  5, G, 1, 0, 0, 1, 0, 5));  // WAIT 1, not ready
    tbl.push_back(mk(0, 0, 1, 0,  5, A, 0, 1, 0, 1, A, 5));  // WAIT 2, ready -> LATCH
    tbl.push_back(mk(0, 0, 0, 0,  5, G, 0, 0, 1, 1, A, 5));  // HOLD after 5 edges
    tbl.push_back(mk(0, 0, 0, 0,  5, G, 0, 0, 1, 1, A, 5));  // HOLD stable
    tbl.push_back(mk(0, 0, 0, 1,  5, G, 0, 0, 0, 0, A, 5));  // ack, no req -> IDLE
    tbl.push_back(mk(0, 0, 1, 0,  5, G, 0, 0, 0, 0, A, 5));  // ready in IDLE ignored
    tbl.push_back(mk(1, 0, 0, 0,  5, G, 1, 0, 0, 1, A, 5));  // ADDR
    tbl.push_back(mk(0, 1, 0, 0,  5, G, 0, 0, 0, 0, A, 5));  // flush in ADDR
    tbl.push_back(mk(1, 0, 0, 0,  5, G, 1, 0, 0, 1, A, 5));  // ADDR
    tbl.push_back(mk(0, 0, 0, 0,  5, G, 1, 0, 0, 1, A, 5));  // WAIT
    tbl.push_back(mk(0, 1, 1, 0,  5, G, 0, 0, 0, 0, A, 5));  // flush+ready in WAIT
    tbl.push_back(mk(1, 0, 0, 0,  5, G, 1, 0, 0, 1, A, 5));  // ADDR
    tbl.push_back(mk(0, 0, 0, 0,  5, G, 1, 0, 0, 1, A, 5));  // WAIT
    tbl.push_back(mk(0, 0, 1, 0,  5, B, 0, 1, 0, 1, B, 5));  // LATCH
    tbl.push_back(mk(0, 1, 0, 0,  5, G, 0, 0, 0, 0, B, 5));  // flush in LATCH -> IDLE
    tbl.push_back(mk(1, 0, 0, 0,  5, G, 1, 0, 0, 1, B, 5));  // ADDR
    tbl.push_back(mk(0, 0, 0, 0,  5, G, 1, 0, 0, 1, B, 5));  // WAIT
    tbl.push_back(mk(0, 1, 0, 0,  5, G, 0, 0, 0, 1, B, 5));  // flush, no ready -> DRAIN
    tbl.push_back(mk(1, 0, 0, 0, 77, G, 0, 0, 0, 1, B, 5));  // req ignored in DRAIN
    tbl.push_back(mk(0, 0, 1, 0, 77, G, 0, 0, 0, 0, B, 5));  // ready -> IDLE, no load
    tbl.push_back(mk(1, 0, 0, 0, 40, G, 1, 0, 0, 1, B, 40)); // new PC sampled
    tbl.push_back(mk(0, 0, 1, 0, 40, G, 1, 0, 0, 1, B, 40)); // ready in ADDR ignored
    tbl.push_back(mk(0, 0, 1, 0, 40, C, 0, 1, 0, 1, C, 40)); // LATCH
    tbl.push_back(mk(0, 0, 0, 0, 40, G, 0, 0, 1, 1, C, 40)); // HOLD
    tbl.push_back(mk(1, 1, 0, 1, 99, G, 0, 0, 0, 0, C, 40)); // flush beats ack+req

    for (int i = 0; i < tbl.size(); i++) begin
      bus.fetch_req = tbl[i].req;
      bus.flush     = tbl[i].flush;
      bus.mem_ready = tbl[i].ready;
      bus.ir_ack    = tbl[i].ack;
      bus.pc_value  = tbl[i].pc;
      bus.mem_data  = tbl[i].data;
      tick();
      check($sformatf("vec%0d.mem_read", i), bus.mem_read, tbl[i].rd);
      check($sformatf("vec%0d.inc_pc", i), bus.inc_pc, tbl[i].inc);
      check($sformatf("vec%0d.pc_enable", i), bus.pc_enable, tbl[i].inc);
      check($sformatf("vec%0d.ir_valid", i), bus.ir_valid, tbl[i].vld);
      check($sformatf("vec%0d.busy", i), bus.busy, tbl[i].bsy);
      check($sformatf("vec%0d.ir_out", i), bus.ir_out, tbl[i].ir);
      check($sformatf("vec%0d.mem_addr", i), 32'(bus.mem_addr), tbl[i].addr);
      check($sformatf("vec%0d.fetch_fault", i), bus.fetch_fault, 1'b0);
    end

    // ---------------- minimum latency: ready on first WAIT cycle ----------------
    do_reset();
    bus.pc_value  = 8;
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    tick();
    check("lat.edge2_valid", bus.ir_valid, 1'b0);
    bus.mem_ready = 1'b1;
    bus.mem_data  = 32'h0BAD_F00D;
    tick();
    check("lat.edge3_valid", bus.ir_valid, 1'b0);
    check("lat.edge3_inc", bus.inc_pc, 1'b1);
    bus.mem_ready = 1'b0;
    tick();
    check("lat.edge4_valid", bus.ir_valid, 1'b1);
    check("lat.ir_out", bus.ir_out, 32'h0BAD_F00D);
    check("lat.mem_addr", 32'(bus.mem_addr), 32'd8);
    bus.ir_ack = 1'b1;
    tick();
    bus.ir_ack = 1'b0;
    check("lat.idle", bus.busy, 1'b0);

    // ---------------- back-to-back fetch with PC model ----------------
    do_reset();
    pc_reg = 5; inc_seen = 1'b0; inc_count = 0; got = 0;
    bus.pc_value  = 5;
    bus.fetch_req = 1'b1;
    for (int c = 0; c < 40 && !(got == 2 && !bus.busy); c++) begin
      prev_read = bus.mem_read;
      tick_pc();
      if (bus.mem_read && !prev_read) addrs.push_back(bus.mem_addr);
      bus.mem_ready = bus.mem_read;
      bus.mem_data  = 32'hC0DE_0000 | 32'(bus.mem_addr);
      if (bus.ir_valid) begin
        check("b2b.ir_out", bus.ir_out, 32'hC0DE_0005 + 32'(got));
        got++;
        bus.ir_ack = 1'b1;
        if (got == 2) bus.fetch_req = 1'b0;
      end else begin
        bus.ir_ack = 1'b0;
      end
    end
    bus.mem_ready = 1'b0;
    bus.ir_ack    = 1'b0;
    check("b2b.fetches", got, 2);
    check("b2b.reads", addrs.size(), 2);
    if (addrs.size() == 2) begin
      check("b2b.addr0", 32'(addrs[0]), 32'd5);
      check("b2b.addr1", 32'(addrs[1]), 32'd6);
    end
    check("b2b.inc_pulses", inc_count, 2);
    check("b2b.pc_final", pc_reg, 7);
    check("b2b.idle", bus.busy, 1'b0);

    // ---------------- async clear mid-WAIT ----------------
    bus.pc_value  = 33;
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    tick();
    tick();
    check("aclr.pre_read", bus.mem_read, 1'b1);
    check("aclr.pre_addr", 32'(bus.mem_addr), 32'd33);
    #2 clear = 1'b1;
    #1;
    check("aclr.mem_read", bus.mem_read, 1'b0);
    check("aclr.busy", bus.busy, 1'b0);
    check("aclr.inc_pc", bus.inc_pc, 1'b0);
    check("aclr.pc_enable", bus.pc_enable, 1'b0);
    check("aclr.ir_valid", bus.ir_valid, 1'b0);
    check("aclr.mem_addr", 32'(bus.mem_addr), 32'd0);
    check("aclr.ir_out", bus.ir_out, 32'd0);
    tick();
    clear = 1'b0;
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("aclr.no_inc", bus.inc_pc, 1'b0);
      check("aclr.stay_idle", bus.busy, 1'b0);
    end
    bus.mem_ready = 1'b0;

`ifdef FETCH_TIMEOUT_EN
    // ---------------- watchdog fault ----------------
    do_reset();
    bus.pc_value  = 12;
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("tmo.waiting", bus.busy, 1'b1);
      check("tmo.no_fault_yet", bus.fetch_fault, 1'b0);
      check("tmo.no_inc", bus.inc_pc, 1'b0);
    end
    tick();
    check("tmo.fault", bus.fetch_fault, 1'b1);
    check("tmo.idle", bus.busy, 1'b0);
    check("tmo.read_off", bus.mem_read, 1'b0);
    check("tmo.no_inc_exit", bus.inc_pc, 1'b0);
    bus.fetch_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("tmo.req_ignored", bus.busy, 1'b0);
      check("tmo.sticky", bus.fetch_fault, 1'b1);
    end
    do_reset();
    check("tmo.cleared", bus.fetch_fault, 1'b0);
`else
    // ---------------- WAIT holds indefinitely without the watchdog ----------------
    do_reset();
    bus.pc_value  = 12;
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    repeat (20) tick();
    check("hold.busy", bus.busy, 1'b1);
    check("hold.read", bus.mem_read, 1'b1);
    check("hold.no_fault", bus.fetch_fault, 1'b0);
    bus.mem_ready = 1'b1;
    bus.mem_data  = 32'h5555_AAAA;
    tick();
    bus.mem_ready = 1'b0;
    check("hold.inc", bus.inc_pc, 1'b1);
    tick();
    check("hold.valid", bus.ir_valid, 1'b1);
    check("hold.ir_out", bus.ir_out, 32'h5555_AAAA);
    bus.ir_ack = 1'b1;
    tick();
    bus.ir_ack = 1'b0;
    check("hold.idle", bus.busy, 1'b0);
`endif

    // ---------------- randomized run against the PC/memory model ----------------
    do_reset();
    pc_start = $urandom;
    pc_reg = pc_start; inc_seen = 1'b0; inc_count = 0; delivered = 0; streak = 0;
    bus.pc_value = pc_reg;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1, pc_start);
    for (int c = 0; c < 100 && bus.busy; c++) rand_cycle(1'b0, pc_start);
    check("rand.drained", bus.busy, 1'b0);
    tick_pc();
    check("rand.inc_vs_fetches", inc_count, delivered);
    check("rand.pc_advance", pc_reg - pc_start, delivered);
    check("rand.some_fetches", (delivered > 50), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
